// File: rtl/image_scaler_core.sv
// image_scaler_core: walks every destination pixel in raster order, fetches
// the source sample(s) it needs from a synchronous source memory, and emits
// one destination write per pixel (nearest zoom in/out, box-average zoom out).
module image_scaler_core #(
    parameter int SRC_W  = 160,
    parameter int SRC_H  = 120,
    parameter int PIX_W  = 8,
    parameter int SRC_AW = 15,
    parameter int DST_AW = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        algorithm_select,
    input  logic [2:0]        zoom_level,
    input  logic              start_pulse,
    output logic              processing_done,
    output logic              busy,
    output logic              src_rd_en,
    output logic [SRC_AW-1:0] src_rd_addr,
    input  logic [PIX_W-1:0]  src_rd_data,
    output logic              dst_wr_en,
    output logic [DST_AW-1:0] dst_wr_addr,
    output logic [PIX_W-1:0]  dst_wr_data,
    input  logic              dst_wr_ready
);

    // Coordinates must cover the largest (x4) destination image.
    localparam int XW = $clog2(4 * SRC_W + 1);
    localparam int YW = $clog2(4 * SRC_H + 1);
    localparam int AW = PIX_W + 4;

    localparam logic [XW-1:0]     SRC_W_X = XW'(SRC_W);
    localparam logic [YW-1:0]     SRC_H_Y = YW'(SRC_H);
    localparam logic [SRC_AW-1:0] SRC_W_A = SRC_AW'(SRC_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [1:0]        r_alg;
    logic [2:0]        r_zoom;
    logic [XW-1:0]     r_dx;
    logic [YW-1:0]     r_dy;
    logic [3:0]        r_rdCnt;
    logic              r_rdValid;
    logic [AW-1:0]     r_acc;
    logic [DST_AW-1:0] r_dstAddr;

    logic [1:0]        w_shift;
    logic              w_zoomIn;
    logic              w_zoomOut;
    logic              w_avg;
    logic [3:0]        w_lastCnt;
    logic [1:0]        w_subI;
    logic [1:0]        w_subJ;
    logic [XW-1:0]     w_dstW;
    logic [YW-1:0]     w_dstH;
    logic [XW-1:0]     w_sx;
    logic [YW-1:0]     w_sy;
    logic [SRC_AW-1:0] w_srcAddr;
    logic [2:0]        w_avgShift;
    logic              w_lastRead;
    logic              w_lastPixel;
    logic              w_startOk;
    logic              w_accept;

    // Decode the latched zoom/algorithm into shift, direction and block geometry;
    // reserved zoom codes fall through to x1 and average only applies to zoom-out.
    always_comb begin
        w_shift   = 2'd0;
        w_zoomIn  = 1'b0;
        w_zoomOut = 1'b0;
        case (r_zoom)
            3'd0: begin w_shift = 2'd2; w_zoomOut = 1'b1; end
            3'd1: begin w_shift = 2'd1; w_zoomOut = 1'b1; end
            3'd3: begin w_shift = 2'd1; w_zoomIn  = 1'b1; end
            3'd4: begin w_shift = 2'd2; w_zoomIn  = 1'b1; end
            default: ;
        endcase
        w_avg      = (r_alg == 2'b01) && w_zoomOut;
        w_lastCnt  = 4'd0;
        w_subI     = 2'd0;
        w_subJ     = 2'd0;
        w_avgShift = 3'd0;
        if (w_avg) begin
            w_avgShift = {w_shift, 1'b0};
            if (w_shift == 2'd2) begin
                w_lastCnt = 4'd15;
                w_subI    = r_rdCnt[1:0];
                w_subJ    = r_rdCnt[3:2];
            end else begin
                w_lastCnt = 4'd3;
                w_subI    = {1'b0, r_rdCnt[0]};
                w_subJ    = {1'b0, r_rdCnt[1]};
            end
        end
    end

    // Destination size, current source coordinate and its linear address.
    always_comb begin
        if (w_zoomIn) begin
            w_dstW = SRC_W_X << w_shift;
            w_dstH = SRC_H_Y << w_shift;
            w_sx   = r_dx >> w_shift;
            w_sy   = r_dy >> w_shift;
        end else begin
            w_dstW = SRC_W_X >> w_shift;
            w_dstH = SRC_H_Y >> w_shift;
            w_sx   = (r_dx << w_shift) + XW'(w_subI);
            w_sy   = (r_dy << w_shift) + YW'(w_subJ);
        end
        w_srcAddr = SRC_AW'(w_sy) * SRC_W_A + SRC_AW'(w_sx);
    end

    assign w_lastRead  = (r_rdCnt == w_lastCnt);
    assign w_lastPixel = (r_dx == w_dstW - XW'(1)) && (r_dy == w_dstH - YW'(1));
    assign w_startOk   = start_pulse && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_accept    = dst_wr_en && dst_wr_ready;

    assign busy            = (r_state == S_READ) || (r_state == S_WAIT) || (r_state == S_WRITE);
    assign processing_done = (r_state == S_DONE);
    assign src_rd_en       = (r_state == S_READ);
    assign src_rd_addr     = src_rd_en ? w_srcAddr : '0;
    assign dst_wr_en       = (r_state == S_WRITE);
    assign dst_wr_addr     = r_dstAddr;
    assign dst_wr_data     = dst_wr_en ? PIX_W'(r_acc >> w_avgShift) : '0;

    // Next-state logic: reads until the last sample, one wait for the final
    // datum, then hold the write until the framebuffer accepts it.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (w_startOk) w_nextState = S_READ;
            S_READ:  if (w_lastRead) w_nextState = S_WAIT;
            S_WAIT:  w_nextState = S_WRITE;
            S_WRITE: if (w_accept) w_nextState = w_lastPixel ? S_DONE : S_READ;
            S_DONE:  if (w_startOk) w_nextState = S_READ;
            default: w_nextState = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_nextState;
    end

    // Job configuration is captured once per accepted start so mid-job input
    // changes cannot disturb the walk.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alg  <= 2'b00;
            r_zoom <= 3'd2;
        end else if (w_startOk) begin
            r_alg  <= algorithm_select;
            r_zoom <= zoom_level;
        end
    end

    // Destination raster position and write address advance only on accepted writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dx      <= '0;
            r_dy      <= '0;
            r_dstAddr <= '0;
        end else if (w_startOk) begin
            r_dx      <= '0;
            r_dy      <= '0;
            r_dstAddr <= '0;
        end else if ((r_state == S_WRITE) && w_accept) begin
            r_dstAddr <= r_dstAddr + DST_AW'(1);
            if (!w_lastPixel) begin
                if (r_dx == w_dstW - XW'(1)) begin
                    r_dx <= '0;
                    r_dy <= r_dy + YW'(1);
                end else begin
                    r_dx <= r_dx + XW'(1);
                end
            end
        end
    end

    // Per-pixel read counter; it indexes the k x k block j-major, i-minor.
    always_ff @(posedge clk) begin
        if (reset || w_startOk) r_rdCnt <= 4'd0;
        else if (r_state == S_READ) r_rdCnt <= w_lastRead ? 4'd0 : r_rdCnt + 4'd1;
    end

    // Accumulator clears on a pixel's first read and adds each datum on the
    // cycle the source memory presents it (one cycle after the read strobe).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdValid <= 1'b0;
            r_acc     <= '0;
        end else begin
            r_rdValid <= src_rd_en;
            if ((r_state == S_READ) && (r_rdCnt == 4'd0)) r_acc <= '0;
            else if (r_rdValid) r_acc <= r_acc + AW'(src_rd_data);
        end
    end

endmodule
